// File: rtl/avr_uart_tx.sv
// -----------------------------------------------------------------------------
// avr_uart_tx
//
// Memory-mapped 8N1 UART transmitter on the avr_cpu data bus. It sits in
// parallel with the data RAM. CPU byte writes to ADDR_DATA are queued in a
// small FIFO and sent on tx, LSB first. The CPU polls ADDR_STATUS for
//   {4'b0, overflow, busy, empty, full}.
// Read data is registered, so reads have the same one-cycle latency as the
// data RAM. data_sel is the matching bus-mux select.
//
// Parameters
//   ADDR_DATA    write: enqueue byte; read: returns 8'h00
//   ADDR_STATUS  read: status byte; writes ignored
//   DIVISOR      clk cycles per serial bit (1..65535)
//   FIFO_DEPTH   FIFO entries, power of two, >= 2
//
// Ports
//   clk         clock, all state updates on posedge
//   reset       synchronous, active-low
//   data_addr   CPU data address
//   data_wen    CPU write strobe (one cycle per access)
//   data_ren    CPU read strobe (one cycle per access)
//   data_write  CPU write data
//   data_read   registered read data, valid the cycle after data_ren
//   data_sel    registered, high while data_read carries a hit
//   tx          serial line, idle high, registered
// -----------------------------------------------------------------------------
module avr_uart_tx #(
  parameter logic [15:0] ADDR_DATA   = 16'h0030,
  parameter logic [15:0] ADDR_STATUS = 16'h0031,
  parameter int unsigned DIVISOR     = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_addr,
  input  logic        data_wen,
  input  logic        data_ren,
  input  logic [7:0]  data_write,
  output logic [7:0]  data_read,
  output logic        data_sel,
  output logic        tx
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      DIV_RELOAD = 16'(DIVISOR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Status byte layout seen by the CPU.
  function automatic logic [DATA_W-1:0] pack_status(
    input logic ovf_bit,
    input logic busy_bit,
    input logic empty_bit,
    input logic full_bit
  );
    pack_status = {4'b0000, ovf_bit, busy_bit, empty_bit, full_bit};
  endfunction

  // ---------------------------------------------------------------------------
  // p0: bus decode (combinational, from the strobes of the current cycle)
  // ---------------------------------------------------------------------------
  logic wr_hit_p0;
  logic rd_data_hit_p0;
  logic rd_stat_hit_p0;

  assign wr_hit_p0      = data_wen && (data_addr == ADDR_DATA);
  assign rd_data_hit_p0 = data_ren && (data_addr == ADDR_DATA);
  assign rd_stat_hit_p0 = data_ren && (data_addr == ADDR_STATUS);

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);

  // Full is sampled before the same-edge pop, so a write to a full FIFO is
  // dropped even when the transmitter frees a slot at that edge.
  assign push = wr_hit_p0 && !fifo_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count/pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_nxt;
  logic [15:0]       div_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              bit_end;
  logic              last_bit;
  logic              busy;

  logic              tx_nxt;
  logic              div_load;
  logic              div_dec;
  logic              bit_clr;
  logic              bit_inc;
  logic              shift;

  // div_cnt counts down from DIVISOR-1; reaching zero ends the current bit.
  assign bit_end  = (div_cnt == '0);
  assign last_bit = (bit_cnt == 3'd7);
  assign busy     = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end && last_bit) begin
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_nxt = fifo_empty ? S_IDLE : S_START;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // tx_nxt is the line level for the cycle after this edge. A pop always
  // starts a start bit, which is how back-to-back frames avoid an idle gap.
  always_comb begin
    pop      = 1'b0;
    tx_nxt   = tx;
    div_load = 1'b0;
    div_dec  = 1'b0;
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    shift    = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop      = 1'b1;
          tx_nxt   = 1'b0;
          div_load = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_nxt   = shreg[0];
          div_load = 1'b1;
          bit_clr  = 1'b1;
        end else begin
          div_dec = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          div_load = 1'b1;
          if (last_bit) begin
            tx_nxt = 1'b1;
          end else begin
            // shreg[0] is the bit on the line now; the next one is shreg[1].
            tx_nxt  = shreg[1];
            shift   = 1'b1;
            bit_inc = 1'b1;
          end
        end else begin
          div_dec = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          div_load = 1'b1;
          if (!fifo_empty) begin
            pop    = 1'b1;
            tx_nxt = 1'b0;
          end else begin
            tx_nxt = 1'b1;
          end
        end else begin
          div_dec = 1'b1;
        end
      end
      default: begin
        tx_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx      <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      tx <= tx_nxt;
      if (div_load) begin
        div_cnt <= DIV_RELOAD;
      end else if (div_dec) begin
        div_cnt <= div_cnt - 1'b1;
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (bit_inc) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= fifo_mem[rd_ptr];
    end else if (shift) begin
      shreg <= {1'b0, shreg[DATA_W-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flag: set by a dropped write, cleared by a status read; a new
  // overflow at the same edge as the clearing read wins.
  // ---------------------------------------------------------------------------
  logic ovf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (wr_hit_p0 && fifo_full) begin
      ovf <= 1'b1;
    end else if (rd_stat_hit_p0) begin
      ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // p1: registered read data; status captured from pre-edge state
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1     <= rd_data_hit_p0 || rd_stat_hit_p0;
      rd_data_p1 <= rd_stat_hit_p0 ? pack_status(ovf, busy, fifo_empty, fifo_full)
                                   : '0;
    end
  end

  assign data_read = rd_data_p1;
  assign data_sel  = vld_p1;

endmodule

// File: tb/tb_avr_uart_tx.sv
module tb_avr_uart_tx;

  localparam logic [15:0] A_DATA = 16'h0030;
  localparam logic [15:0] A_STAT = 16'h0031;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_addr = '0;
  logic        data_wen = 1'b0;
  logic        data_ren = 1'b0;
  logic [7:0]  data_write = '0;
  logic [7:0]  data_read;
  logic        data_sel;
  logic        tx;

  avr_uart_tx #(
    .ADDR_DATA  (A_DATA),
    .ADDR_STATUS(A_STAT),
    .DIVISOR    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_addr (data_addr),
    .data_wen  (data_wen),
    .data_ren  (data_ren),
    .data_write(data_write),
    .data_read (data_read),
    .data_sel  (data_sel),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level reference model: a byte queue, an active frame and its phase.
  // ---------------------------------------------------------------------------
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic       m_valid  = 1'b0;
  logic       m_active = 1'b0;
  logic       m_ovf    = 1'b0;
  logic       m_tx     = 1'b1;
  logic       m_sel    = 1'b0;
  logic [7:0] m_rd     = '0;
  logic [7:0] m_cur    = '0;
  logic [7:0] m_stat;
  int         m_phase  = 0;
  int         m_n;
  logic       m_pop, m_wr, m_rs, m_rdd, m_oset;

  // Bit i of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_phase  = 0;
      m_ovf    = 1'b0;
      m_tx     = 1'b1;
      m_sel    = 1'b0;
      m_rd     = '0;
      m_valid  = 1'b1;
    end else begin
      m_n    = m_q.size();
      m_stat = {4'b0000, m_ovf, (m_active || m_n != 0), (m_n == 0), (m_n == DEPTH)};
      m_wr   = data_wen && (data_addr == A_DATA);
      m_rdd  = data_ren && (data_addr == A_DATA);
      m_rs   = data_ren && (data_addr == A_STAT);
      m_pop  = 1'b0;
      m_oset = 1'b0;
      if (!m_active) begin
        m_pop = (m_n != 0);
      end else begin
        m_phase++;
        if (m_phase == 10 * DIV) begin
          if (m_n != 0) m_pop = 1'b1;
          else          m_active = 1'b0;
        end
      end
      if (m_pop) begin
        m_cur = m_q.pop_front();
        m_sent.push_back(m_cur);
        m_active = 1'b1;
        m_phase  = 0;
      end
      if (m_wr) begin
        if (m_n < DEPTH) m_q.push_back(data_write);
        else             m_oset = 1'b1;
      end
      if (m_oset)    m_ovf = 1'b1;
      else if (m_rs) m_ovf = 1'b0;
      m_sel = m_rdd || m_rs;
      m_rd  = m_rs ? m_stat : 8'h00;
      m_tx  = m_active ? frame_bit(m_cur, m_phase / DIV) : 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("tx", {31'b0, tx}, {31'b0, m_tx});
      check("data_sel", {31'b0, data_sel}, {31'b0, m_sel});
      check("data_read", {24'b0, data_read}, {24'b0, m_rd});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called from a negedge position)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d);
    data_wen   = w;
    data_ren   = r;
    data_addr  = a;
    data_write = d;
  endtask

  task automatic bus(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    drive(w, r, a, d);
  endtask

  task automatic wait_after(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Read strobe sampled at posedge e; returns what the bus shows after it.
  task automatic read_at(input int e, input logic [15:0] a, output logic [7:0] v, output logic s);
    wait_after(e - 1);
    drive(1'b0, 1'b1, a, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    v = data_read;
    s = data_sel;
  endtask

  // Sample the middle of each bit of a frame whose start bit begins at edge m.
  task automatic capture_frame(input int m, output logic [9:0] bits);
    for (int k = 0; k < 10; k++) begin
      wait_after(m + k * DIV + 2);
      bits[k] = tx;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic       s;
    logic [9:0] fb;
    int         n;
    int         base;

    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_sel", {31'b0, data_sel}, 32'd0);
    check("rst_read", {24'b0, data_read}, 32'h00);

    // Status after reset: empty only.
    read_at(cyc + 2, A_STAT, v, s);
    check("rst_status", {24'b0, v}, 32'h02);
    check("rst_status_sel", {31'b0, s}, 32'd1);
    @(negedge clk);
    check("status_sel_one_cycle", {31'b0, data_sel}, 32'd0);

    // Unmapped neighbour address.
    read_at(cyc + 1, 16'h0032, v, s);
    check("miss_read", {24'b0, v}, 32'h00);
    check("miss_sel", {31'b0, s}, 32'd0);

    // Single byte 8'h55.
    bus(1'b1, 1'b0, A_DATA, 8'h55);
    n = cyc + 1;
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    check("55_before_start", {31'b0, tx}, 32'd1);
    wait_after(n + 1);
    check("55_start_edge", {31'b0, tx}, 32'd0);
    capture_frame(n + 1, fb);
    check("55_frame", {22'b0, fb}, {22'b0, 1'b1, 8'h55, 1'b0});
    read_at(n + 41, A_STAT, v, s);
    check("55_busy_last", {24'b0, v}, 32'h06);
    read_at(n + 42, A_STAT, v, s);
    check("55_idle", {24'b0, v}, 32'h02);

    // Write and read strobes together on the data address.
    base = m_sent.size();
    bus(1'b1, 1'b1, A_DATA, 8'h3A);
    n = cyc + 1;
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    check("wr_rd_sel", {31'b0, data_sel}, 32'd1);
    check("wr_rd_read", {24'b0, data_read}, 32'h00);
    wait_after(n + 45);
    check("wr_rd_model_sent", m_sent.size() - base, 32'd1);
    check("wr_rd_model_byte", {24'b0, m_sent[base]}, 32'h3A);

    // Six back-to-back writes into a 4-deep FIFO.
    base = m_sent.size();
    n    = 0;
    for (int i = 0; i < 6; i++) begin
      bus(1'b1, 1'b0, A_DATA, 8'(i + 1));
      if (i == 0) n = cyc + 1;
    end
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    read_at(n + 10, A_STAT, v, s);
    check("ovf_first_read", {24'b0, v}, 32'h0D);
    read_at(n + 12, A_STAT, v, s);
    check("ovf_second_read", {24'b0, v}, 32'h05);
    read_at(n + 201, A_STAT, v, s);
    check("ovf_last_stop", {24'b0, v}, 32'h06);
    read_at(n + 202, A_STAT, v, s);
    check("ovf_idle", {24'b0, v}, 32'h02);
    check("ovf_model_nsent", m_sent.size() - base, 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("ovf_model_byte", {24'b0, m_sent[base + k]}, 32'(k + 1));
    end

    // Push at the same edge as a pop with count==1.
    bus(1'b1, 1'b0, A_DATA, 8'h69);
    n = cyc + 1;
    bus(1'b1, 1'b0, A_DATA, 8'hA5);
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    read_at(n + 2, A_STAT, v, s);
    check("pushpop_count1", {24'b0, v}, 32'h04);
    capture_frame(n + 41, fb);
    check("pushpop_a5_frame", {22'b0, fb}, {22'b0, 1'b1, 8'hA5, 1'b0});
    wait_after(n + 85);

    // Reset during data bit 3 of a frame with a second byte queued.
    base = m_sent.size();
    bus(1'b1, 1'b0, A_DATA, 8'hC3);
    n = cyc + 1;
    bus(1'b1, 1'b0, A_DATA, 8'h3C);
    bus(1'b0, 1'b0, 16'h0000, 8'h00);
    wait_after(n + 1 + 16);
    check("midrst_bit3", {31'b0, tx}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_tx", {31'b0, tx}, 32'd1);
    reset = 1'b1;
    wait_after(cyc + 60);
    read_at(cyc + 2, A_STAT, v, s);
    check("midrst_status", {24'b0, v}, 32'h02);
    check("midrst_model_nsent", m_sent.size() - base, 32'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
